debug_host_link: RTL and testbench

- Host-side initiator for the UART debug protocol.
- Serializes command words into byte writes toward a UART TX FIFO.
- Reassembles the debugger's byte-stream response into words and reports completion or timeout.
- Used on-board and in system benches as the scripted counterpart of the debugger unit, sitting between a command source and a uart instance.

---
 rtl/debug_host_link.sv | 140 ++++++++++++++
 tb/tb_debug_host_link.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_host_link.sv
// debug_host_link: host-side UART debug initiator. Streams a command word out as
// bytes MSB first, then collects and reassembles the debugger's response words.
`default_nettype none

module debug_host_link #(
  parameter int UART_BUS_SIZE = 8,
  parameter int CMD_BUS_SIZE  = 32,
  parameter int RSP_BUS_SIZE  = 32,
  parameter int RSP_TIMEOUT   = 100000
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_cmd_valid,
  input  logic [CMD_BUS_SIZE-1:0]  i_cmd_data,
  input  logic [7:0]               i_rsp_words,
  output logic                     o_cmd_ready,
  input  logic                     i_uart_full,
  output logic                     o_uart_wr,
  output logic [UART_BUS_SIZE-1:0] o_uart_data_wr,
  input  logic                     i_uart_empty,
  input  logic [UART_BUS_SIZE-1:0] i_uart_data_rd,
  output logic                     o_uart_rd,
  output logic                     o_rsp_valid,
  output logic [RSP_BUS_SIZE-1:0]  o_rsp_data,
  output logic                     o_done,
  output logic                     o_timeout,
  output logic                     o_busy
);

  localparam int CMD_BYTES = CMD_BUS_SIZE / UART_BUS_SIZE;
  localparam int RSP_BYTES = RSP_BUS_SIZE / UART_BUS_SIZE;
  localparam int CIW       = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
  localparam int RIW       = (RSP_BYTES > 1) ? $clog2(RSP_BYTES) : 1;
  localparam int TW        = (RSP_TIMEOUT > 1) ? $clog2(RSP_TIMEOUT) : 1;

  localparam logic [CIW-1:0] CMD_LAST = CIW'(CMD_BYTES - 1);
  localparam logic [RIW-1:0] RSP_LAST = RIW'(RSP_BYTES - 1);
  localparam logic [TW-1:0]  TMO_LAST = TW'(RSP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SEND    = 3'd1,
    S_RECV    = 3'd2,
    S_EMIT    = 3'd3,
    S_DONE    = 3'd4,
    S_TIMEOUT = 3'd5
  } state_t;

  state_t                  state;
  logic [CMD_BUS_SIZE-1:0] cmd_shift;
  logic [CIW-1:0]          tx_idx;
  logic [7:0]              words_left;
  logic [RIW-1:0]          rx_cnt;
  logic [TW-1:0]           tmo_cnt;
  logic [RSP_BUS_SIZE-1:0] rsp_asm;
  logic [RSP_BUS_SIZE-1:0] rsp_word;
  logic [RSP_BUS_SIZE-1:0] asm_next;

  // Strobes follow the FIFO flags combinationally so a push never meets a full
  // FIFO and a pop never meets an empty one; reset suppresses them at once.
  assign o_uart_wr   = !i_reset && (state == S_SEND) && !i_uart_full;
  assign o_uart_rd   = !i_reset && (state == S_RECV) && !i_uart_empty;
  assign o_cmd_ready = !i_reset && (state == S_IDLE);
  assign o_busy      = (state != S_IDLE);
  assign o_rsp_valid = !i_reset && (state == S_EMIT);
  assign o_done      = !i_reset && ((state == S_DONE) || (state == S_TIMEOUT));
  assign o_timeout   = !i_reset && (state == S_TIMEOUT);

  assign o_uart_data_wr = cmd_shift[CMD_BUS_SIZE-1 -: UART_BUS_SIZE];
  assign o_rsp_data     = rsp_word;

  assign asm_next = (rsp_asm << UART_BUS_SIZE) | RSP_BUS_SIZE'(i_uart_data_rd);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= S_IDLE;
      cmd_shift  <= '0;
      tx_idx     <= '0;
      words_left <= '0;
      rx_cnt     <= '0;
      tmo_cnt    <= '0;
      rsp_asm    <= '0;
      rsp_word   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_cmd_valid) begin
            cmd_shift  <= i_cmd_data;
            words_left <= i_rsp_words;
            tx_idx     <= '0;
            rx_cnt     <= '0;
            tmo_cnt    <= '0;
            state      <= S_SEND;
          end
        end

        S_SEND: begin
          if (!i_uart_full) begin
            cmd_shift <= cmd_shift << UART_BUS_SIZE;
            tx_idx    <= tx_idx + 1'b1;
            if (tx_idx == CMD_LAST) begin
              state <= (words_left == 8'd0) ? S_DONE : S_RECV;
            end
          end
        end

        S_RECV: begin
          if (!i_uart_empty) begin
            rsp_asm <= asm_next;
            tmo_cnt <= '0;
            rx_cnt  <= rx_cnt + 1'b1;
            if (rx_cnt == RSP_LAST) begin
              rsp_word <= asm_next;
              state    <= S_EMIT;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Any partially assembled word is simply abandoned here.
            state <= S_TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end

        S_EMIT: begin
          words_left <= words_left - 8'd1;
          rx_cnt     <= '0;
          tmo_cnt    <= '0;
          state      <= (words_left == 8'd1) ? S_DONE : S_RECV;
        end

        S_DONE, S_TIMEOUT: state <= S_IDLE;

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_debug_host_link.sv
// Scoreboard bench for debug_host_link: randomized commands, a FIFO model on the
// UART side and a byte-level reference model of the expected traffic.
`timescale 1ns/1ps
`default_nettype none

module tb_debug_host_link;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid;
  logic [31:0] cmd_data;
  logic [7:0]  rsp_words;
  logic        cmd_ready;
  logic        uart_full;
  logic        uart_wr;
  logic [7:0]  uart_data_wr;
  logic        uart_empty;
  logic [7:0]  uart_data_rd;
  logic        uart_rd;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        done;
  logic        timeout;
  logic        busy;

  always #5 clk = ~clk;

  debug_host_link #(
    .UART_BUS_SIZE(8), .CMD_BUS_SIZE(32), .RSP_BUS_SIZE(32), .RSP_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_reset(rst),
    .i_cmd_valid(cmd_valid), .i_cmd_data(cmd_data), .i_rsp_words(rsp_words),
    .o_cmd_ready(cmd_ready),
    .i_uart_full(uart_full), .o_uart_wr(uart_wr), .o_uart_data_wr(uart_data_wr),
    .i_uart_empty(uart_empty), .i_uart_data_rd(uart_data_rd), .o_uart_rd(uart_rd),
    .o_rsp_valid(rsp_valid), .o_rsp_data(rsp_data),
    .o_done(done), .o_timeout(timeout), .o_busy(busy)
  );

  int unsigned npass = 0;
  int unsigned ntotal = 0;

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_rsp[$];
  bit          exp_end[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  stim[$];

  int cyc = 0;
  int last_act = 0;
  int wr_count = 0;
  bit pend_rd = 0;
  bit bp_en = 0;
  bit st_en = 0;
  int stall_run = 0;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (ok) npass++;
    else $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // UART FIFO model: commit pops seen last cycle, then present new flags.
  initial begin
    bit stall;
    uart_full = 1'b0; uart_empty = 1'b1; uart_data_rd = 8'h00;
    forever begin
      @(posedge clk); #1;
      if (pend_rd && rx_q.size() > 0) void'(rx_q.pop_front());
      pend_rd = 0;
      uart_full = bp_en && ($urandom_range(3) == 0);
      stall = st_en && (rx_q.size() > 0) && (stall_run < 4) && ($urandom_range(3) == 0);
      stall_run = stall ? stall_run + 1 : 0;
      uart_empty = (rx_q.size() == 0) || stall;
      uart_data_rd = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  // Monitor: every observable event is matched against the scoreboard.
  initial begin
    logic [7:0] eb;
    logic [31:0] ew;
    bit et;
    forever begin
      @(negedge clk);
      if (uart_wr) begin
        chk(!uart_full, "wr_while_full", 32'(uart_full), 32'd0);
        chk(!uart_rd, "wr_and_rd", 32'(uart_rd), 32'd0);
        if (exp_tx.size() == 0) chk(1'b0, "tx_unexpected", 32'(uart_data_wr), 32'd0);
        else begin
          eb = exp_tx.pop_front();
          chk(uart_data_wr == eb, "tx_byte", 32'(uart_data_wr), 32'(eb));
        end
        last_act = cyc;
        wr_count++;
      end
      if (uart_rd) begin
        chk(!uart_empty, "rd_while_empty", 32'(uart_empty), 32'd0);
        pend_rd = 1;
        last_act = cyc;
      end
      if (rsp_valid) begin
        if (exp_rsp.size() == 0) chk(1'b0, "rsp_unexpected", rsp_data, 32'd0);
        else begin
          ew = exp_rsp.pop_front();
          chk(rsp_data == ew, "rsp_word", rsp_data, ew);
        end
        last_act = cyc;
      end
      if (timeout && !done) chk(1'b0, "timeout_without_done", 32'(done), 32'd1);
      if (done) begin
        if (exp_end.size() == 0) chk(1'b0, "done_unexpected", 32'(done), 32'd0);
        else begin
          et = exp_end.pop_front();
          chk(timeout == et, "end_kind", 32'(timeout), 32'(et));
          chk((cyc - last_act) == (et ? TMO + 1 : 1), "end_latency",
              32'(cyc - last_act), 32'(et ? TMO + 1 : 1));
          chk(exp_tx.size() == 0 && exp_rsp.size() == 0, "leftover_at_end",
              32'(exp_tx.size() + exp_rsp.size()), 32'd0);
        end
      end
    end
  end

  // Reference model: bytes out MSB first; every complete group of four received
  // bytes becomes one word; a short byte supply ends in a timeout.
  task automatic issue_cmd(input logic [31:0] cmd, input logic [7:0] words);
    int n = 0;
    int nfull;
    logic [31:0] w;
    while (!cmd_ready && n < 100) begin @(negedge clk); #1; n++; end
    chk(cmd_ready, "ready_before_issue", 32'(cmd_ready), 32'd1);
    if (!cmd_ready) return;
    for (int i = 3; i >= 0; i--) exp_tx.push_back(8'((cmd >> (8 * i)) & 32'hFF));
    nfull = stim.size() / 4;
    if (nfull > int'(words)) nfull = int'(words);
    for (int k = 0; k < nfull; k++) begin
      w = 32'd0;
      for (int j = 0; j < 4; j++) w = w * 256 + 32'(stim[4 * k + j]);
      exp_rsp.push_back(w);
    end
    exp_end.push_back(stim.size() < 4 * int'(words));
    foreach (stim[i]) rx_q.push_back(stim[i]);
    cmd_valid = 1'b1; cmd_data = cmd; rsp_words = words;
    @(negedge clk); #1;
    cmd_valid = 1'b0; cmd_data = $urandom;
  endtask

  task automatic wait_end();
    int n = 0;
    while (exp_end.size() > 0 && n < 3000) begin
      cmd_valid = busy && ($urandom_range(7) == 0);
      if (cmd_valid) begin cmd_data = $urandom; rsp_words = 8'($urandom); end
      @(negedge clk); #1;
      n++;
    end
    cmd_valid = 1'b0;
    chk(exp_end.size() == 0, "txn_completion", 32'(n), 32'd3000);
  endtask

  task automatic run(input logic [31:0] cmd, input logic [7:0] words);
    issue_cmd(cmd, words);
    wait_end();
  endtask

  task automatic idle_checks(input string tag);
    chk(cmd_ready == 1'b1, {tag, "_ready"}, 32'(cmd_ready), 32'd1);
    chk(busy == 1'b0, {tag, "_busy"}, 32'(busy), 32'd0);
    chk(uart_data_wr == 8'h00, {tag, "_data_wr"}, 32'(uart_data_wr), 32'd0);
    chk(rsp_data == 32'd0, {tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({uart_wr, uart_rd, rsp_valid, done, timeout} == 5'b0, {tag, "_strobes"},
        32'({uart_wr, uart_rd, rsp_valid, done, timeout}), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, actual running required finished");
    $fatal(1);
  end

  initial begin
    int words, nb, base, n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_data = '0; rsp_words = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle_checks("reset");
    #1;

    // No-response command, no backpressure.
    stim.delete();
    run(32'h11223344, 8'd0);
    // Two-word response.
    stim = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h01, 8'h02, 8'h03, 8'h04};
    run(32'h0BADBEEF, 8'd2);
    // Timeout after only two bytes.
    stim = '{8'h5A, 8'hA5};
    run(32'h600DF00D, 8'd1);

    bp_en = 1; st_en = 1;
    for (int t = 0; t < 40; t++) begin
      words = $urandom_range(0, 3);
      nb = 4 * words;
      if (words > 0 && $urandom_range(4) == 0) nb = $urandom_range(0, 4 * words - 1);
      stim.delete();
      for (int i = 0; i < nb; i++) stim.push_back(8'($urandom));
      run($urandom, 8'(words));
    end

    // Reset while the command is half sent.
    bp_en = 0; st_en = 0;
    stim.delete();
    base = wr_count;
    issue_cmd(32'hDEADC0DE, 8'd0);
    n = 0;
    while (wr_count < base + 2 && n < 50) begin @(negedge clk); #1; n++; end
    chk(wr_count >= base + 2, "pre_reset_writes", 32'(wr_count - base), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_tx.delete(); exp_rsp.delete(); exp_end.delete(); rx_q.delete(); pend_rd = 0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    idle_checks("midreset");
    #1;
    run(32'hCAFEF00D, 8'd0);

    bp_en = 1; st_en = 1;
    for (int t = 0; t < 10; t++) begin
      words = $urandom_range(1, 2);
      stim.delete();
      for (int i = 0; i < 4 * words; i++) stim.push_back(8'($urandom));
      run($urandom, 8'(words));
    end

    repeat (4) @(negedge clk);
    chk(exp_tx.size() + exp_rsp.size() + exp_end.size() == 0, "scoreboard_drained",
        32'(exp_tx.size() + exp_rsp.size() + exp_end.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule

`default_nettype wire
